// File: rtl/uart_prog_loader_pkg.sv
// rtl/uart_prog_loader_pkg.sv - shared types and constants for the UART program loader
package uart_prog_loader_pkg;

  localparam int         DEFAULT_CLKS_PER_BIT = 87;
  localparam logic [7:0] HEADER_BYTE          = 8'hA5;

  typedef enum logic [2:0] {
    IDLE,
    CNT_LO,
    CNT_HI,
    DATA,
    DONE,
    ERROR
  } load_state_t;

endpackage

// File: rtl/uart_prog_loader_if.sv
// rtl/uart_prog_loader_if.sv - instruction memory write port between loader and memory
interface uart_prog_loader_if #(
  parameter int ADDR_W = 14
);
  import uart_prog_loader_pkg::*;

  logic              prog_wen;
  logic [ADDR_W-1:0] prog_addr;
  logic [31:0]       prog_wdata;

  modport master (output prog_wen, output prog_addr, output prog_wdata);
  modport slave  (input  prog_wen, input  prog_addr, input  prog_wdata);

endinterface

// File: rtl/uart_rx_8n1.sv
// rtl/uart_rx_8n1.sv - 8N1 UART receiver with start-bit glitch rejection
module uart_rx_8n1
  import uart_prog_loader_pkg::*;
#(
  parameter int CLKS_PER_BIT = DEFAULT_CLKS_PER_BIT
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       rx,
  output logic       byte_valid,
  output logic [7:0] byte_data,
  output logic       frame_err
);

  localparam int CW   = $clog2(CLKS_PER_BIT + 1);
  localparam int HALF = CLKS_PER_BIT / 2;

  typedef enum logic [1:0] {RX_IDLE, RX_START, RX_DATA, RX_STOP} rx_state_t;

  rx_state_t     state;
  logic          rx_meta;
  logic          rx_sync;
  logic          rx_prev;
  logic [CW-1:0] cnt;
  logic [2:0]    bit_idx;

  // Two-flop synchronizer; both flops idle high so reset never fakes a start edge.
  always_ff @(posedge clock) begin
    if (reset) begin
      rx_meta <= 1'b1;
      rx_sync <= 1'b1;
    end else begin
      rx_meta <= rx;
      rx_sync <= rx_meta;
    end
  end

  // Bit timing: arm on falling edge, confirm at mid-start, then sample every bit period.
  always_ff @(posedge clock) begin
    if (reset) begin
      state      <= RX_IDLE;
      rx_prev    <= 1'b1;
      cnt        <= '0;
      bit_idx    <= '0;
      byte_data  <= '0;
      byte_valid <= 1'b0;
      frame_err  <= 1'b0;
    end else begin
      rx_prev    <= rx_sync;
      byte_valid <= 1'b0;
      frame_err  <= 1'b0;
      case (state)
        RX_IDLE: begin
          if (rx_prev && !rx_sync) begin
            state <= RX_START;
            cnt   <= '0;
          end
        end
        RX_START: begin
          if (cnt == CW'(HALF - 1)) begin
            cnt     <= '0;
            bit_idx <= '0;
            state   <= rx_sync ? RX_IDLE : RX_DATA;
          end else begin
            cnt <= cnt + CW'(1);
          end
        end
        RX_DATA: begin
          if (cnt == CW'(CLKS_PER_BIT - 1)) begin
            cnt       <= '0;
            byte_data <= {rx_sync, byte_data[7:1]};
            bit_idx   <= bit_idx + 3'd1;
            if (bit_idx == 3'd7) state <= RX_STOP;
          end else begin
            cnt <= cnt + CW'(1);
          end
        end
        default: begin
          if (cnt == CW'(CLKS_PER_BIT - 1)) begin
            cnt   <= '0;
            state <= RX_IDLE;
            if (rx_sync) byte_valid <= 1'b1;
            else         frame_err  <= 1'b1;
          end else begin
            cnt <= cnt + CW'(1);
          end
        end
      endcase
    end
  end

endmodule

// File: rtl/uart_prog_loader.sv
// rtl/uart_prog_loader.sv - UART boot loader writing a framed program image into instruction memory
module uart_prog_loader
  import uart_prog_loader_pkg::*;
#(
  parameter int CLKS_PER_BIT = DEFAULT_CLKS_PER_BIT,
  parameter int ADDR_W       = 14,
  parameter int TIMEOUT_CLKS = 2_000_000
) (
  input  logic               clock,
  input  logic               reset,
  input  logic               rx,
  input  logic               boot_skip,
  uart_prog_loader_if.master prog,
  output logic               cpu_hold,
  output logic               load_done,
  output logic               load_err
);

  localparam int          GAP_W     = $clog2(TIMEOUT_CLKS + 1);
  localparam logic [31:0] MAX_WORDS = 32'd1 << ADDR_W;

  logic              byte_valid;
  logic              frame_err;
  logic [7:0]        byte_data;
  load_state_t       state;
  load_state_t       state_n;
  logic [15:0]       count;
  logic [15:0]       count_full;
  logic [GAP_W-1:0]  gap_cnt;
  logic [1:0]        byte_idx;
  logic [31:0]       word_buf;
  logic              wen_q;
  logic [ADDR_W-1:0] addr_q;
  logic [31:0]       wdata_q;
  logic              active;
  logic              timeout;

  uart_rx_8n1 #(
    .CLKS_PER_BIT(CLKS_PER_BIT)
  ) u_rx (
    .clock      (clock),
    .reset      (reset),
    .rx         (rx),
    .byte_valid (byte_valid),
    .byte_data  (byte_data),
    .frame_err  (frame_err)
  );

  assign prog.prog_wen   = wen_q;
  assign prog.prog_addr  = addr_q;
  assign prog.prog_wdata = wdata_q;

  assign active     = (state == CNT_LO) || (state == CNT_HI) || (state == DATA);
  assign timeout    = active && (gap_cnt == GAP_W'(TIMEOUT_CLKS - 1));
  assign count_full = {byte_data, count[7:0]};

  // Next-state decision; a received byte takes priority over a coincident timeout.
  always_comb begin
    state_n = state;
    if (active && frame_err) begin
      state_n = ERROR;
    end else if (byte_valid) begin
      case (state)
        IDLE, DONE, ERROR: if (byte_data == HEADER_BYTE) state_n = CNT_LO;
        CNT_LO:            state_n = CNT_HI;
        CNT_HI: begin
          if (count_full == 16'd0)                  state_n = DONE;
          else if ({16'd0, count_full} > MAX_WORDS) state_n = ERROR;
          else                                      state_n = DATA;
        end
        default: ;
      endcase
    end else if (timeout) begin
      state_n = ERROR;
    end else if (state == DATA && wen_q && count == 16'd1) begin
      state_n = DONE;
    end
  end

  // Loader state, gap counter, word assembly and registered status outputs.
  always_ff @(posedge clock) begin
    if (reset) begin
      state     <= IDLE;
      count     <= '0;
      gap_cnt   <= '0;
      byte_idx  <= '0;
      word_buf  <= '0;
      wen_q     <= 1'b0;
      addr_q    <= '0;
      wdata_q   <= '0;
      cpu_hold  <= 1'b1;
      load_done <= 1'b0;
      load_err  <= 1'b0;
    end else begin
      state <= state_n;
      wen_q <= 1'b0;

      if (byte_valid || !active) gap_cnt <= '0;
      else if (!timeout)         gap_cnt <= gap_cnt + GAP_W'(1);

      if (byte_valid) begin
        case (state)
          IDLE, DONE, ERROR: begin
            if (byte_data == HEADER_BYTE) begin
              addr_q   <= '0;
              count    <= '0;
              byte_idx <= '0;
            end
          end
          CNT_LO: count[7:0]  <= byte_data;
          CNT_HI: count[15:8] <= byte_data;
          default: begin
            word_buf[{byte_idx, 3'b000} +: 8] <= byte_data;
            byte_idx <= byte_idx + 2'd1;
            if (byte_idx == 2'd3) begin
              wen_q   <= 1'b1;
              wdata_q <= {byte_data, word_buf[23:0]};
            end
          end
        endcase
      end

      // The address advances only after the memory has seen the strobe.
      if (wen_q) begin
        addr_q <= addr_q + ADDR_W'(1);
        count  <= count - 16'd1;
      end

      if (state_n == ERROR) byte_idx <= '0;

      cpu_hold  <= (state_n == IDLE) ? ~boot_skip : (state_n != DONE);
      load_done <= (state_n == DONE);
      load_err  <= (state_n == ERROR);
    end
  end

endmodule
